// File: rtl/grey_decoder_seq.sv
// Registered gray-to-binary decoder with valid/ready handshake and step classification.
// Step checking (flags, err_cnt, prev_b, have_prev) is built only with GREY_DECODER_STEP_CHECK_EN defined.
module grey_decoder_seq #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         g_valid,
   input  logic [N-1:0] g,
   output logic         g_ready,
   output logic         b_valid,
   output logic [N-1:0] b,
   input  logic         b_ready,
   output logic         step_up,
   output logic         step_dn,
   output logic         step_err,
   output logic [7:0]   err_cnt
);

   function automatic logic [N-1:0] gray2bin(input logic [N-1:0] gw);
      logic [N-1:0] bw;
      bw[N-1] = gw[N-1];
      for (int i = N - 2; i >= 0; i--) begin
         bw[i] = bw[i+1] ^ gw[i];
      end
      return bw;
   endfunction

   logic         accept_s;
   logic [N-1:0] dec_s;
   logic [N-1:0] b_q, b_d;
   logic         bv_q, bv_d;

   // Ready looks only at the registered valid and downstream ready, never at g_valid.
   assign g_ready  = !bv_q || b_ready;
   assign accept_s = g_valid && g_ready;
   assign dec_s    = gray2bin(g);
   assign b        = b_q;
   assign b_valid  = bv_q;

   // Output word next-state: load on accept, drop valid on a pure drain.
   always_comb begin
      b_d  = b_q;
      bv_d = bv_q;
      if (accept_s) begin
         b_d  = dec_s;
         bv_d = 1'b1;
      end else if (bv_q && b_ready) begin
         bv_d = 1'b0;
      end else begin
         bv_d = bv_q;
      end
   end

   // Output word registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q  <= {N{1'b0}};
         bv_q <= 1'b0;
      end else begin
         b_q  <= b_d;
         bv_q <= bv_d;
      end
   end

`ifdef GREY_DECODER_STEP_CHECK_EN
   localparam logic [N-1:0] ONE = N'(1);

   logic [N-1:0] prev_q, prev_d;
   logic         have_q, have_d;
   logic         up_q, up_d, dn_q, dn_d, err_q, err_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         is_up_s, is_dn_s;

   // For N=1 the +1 and -1 neighbours coincide; up takes priority.
   assign is_up_s = (dec_s == prev_q + ONE);
   assign is_dn_s = (dec_s == prev_q - ONE) && !is_up_s;

   // Step classification; flags and counter only move on an accept.
   always_comb begin
      prev_d = prev_q;
      have_d = have_q;
      up_d   = up_q;
      dn_d   = dn_q;
      err_d  = err_q;
      cnt_d  = cnt_q;
      if (accept_s) begin
         prev_d = dec_s;
         have_d = 1'b1;
         if (have_q) begin
            up_d  = is_up_s;
            dn_d  = is_dn_s;
            err_d = !(is_up_s || is_dn_s);
            if (!(is_up_s || is_dn_s) && (cnt_q != 8'hFF)) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end else begin
            up_d  = 1'b0;
            dn_d  = 1'b0;
            err_d = 1'b0;
         end
      end else begin
         prev_d = prev_q;
      end
   end

   // Step-check state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= {N{1'b0}};
         have_q <= 1'b0;
         up_q   <= 1'b0;
         dn_q   <= 1'b0;
         err_q  <= 1'b0;
         cnt_q  <= 8'd0;
      end else begin
         prev_q <= prev_d;
         have_q <= have_d;
         up_q   <= up_d;
         dn_q   <= dn_d;
         err_q  <= err_d;
         cnt_q  <= cnt_d;
      end
   end

   assign step_up  = up_q;
   assign step_dn  = dn_q;
   assign step_err = err_q;
   assign err_cnt  = cnt_q;
`else
   assign step_up  = 1'b0;
   assign step_dn  = 1'b0;
   assign step_err = 1'b0;
   assign err_cnt  = 8'd0;
`endif

endmodule
